// File: rtl/pc_pkg.sv
// pc_pkg: shared PC-write modes, sequencer states and instruction lengths
package pc_pkg;
  localparam logic [1:0] PCINC  = 2'b00;
  localparam logic [1:0] PCBRCH = 2'b01;
  localparam logic [1:0] PCJREG = 2'b10;
  localparam logic [1:0] PCJIMM = 2'b11;
  localparam logic [31:0] LEN_FULL = 32'd4;
  localparam logic [31:0] LEN_COMP = 32'd2;
  typedef enum logic {FETCH, EXEC} state_e;
endpackage

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the architectural PC, fetch handshake, misalign trap and retire count
module pc_sequencer
  import pc_pkg::*;
#(
  parameter logic [31:0] ResetVector = 32'h0000_0000,
  parameter logic [31:0] TrapVector  = 32'h0000_0010
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [1:0]  CtrlPCMode,
  input  logic        InstrCompressed,
  input  logic [31:0] Imm,
  input  logic [31:0] AluRd,
  input  logic        Flag,
  input  logic        Step,
  input  logic        Redirect,
  input  logic [31:0] RedirectAddr,
  output logic        FetchReq,
  output logic [31:0] FetchAddr,
  input  logic        FetchAck,
  output logic [31:0] PC,
  output logic [31:0] LinkAddr,
  output logic        MisalignTrap,
  output logic [31:0] TrapValue,
  output logic [31:0] InstRet,
  output logic        Busy
);
  state_e      state_q;
  logic [31:0] pc_q, trap_val_q, instret_q, len, tgt_imm, next_pc_d;
  logic        fetch_req_q, trap_q;
  assign len       = InstrCompressed ? LEN_COMP : LEN_FULL;
  assign LinkAddr  = pc_q + len;
  assign tgt_imm   = pc_q + Imm;
  assign PC        = pc_q;
  assign FetchAddr = pc_q;
  assign FetchReq  = fetch_req_q;
  assign MisalignTrap = trap_q;
  assign TrapValue = trap_val_q;
  assign InstRet   = instret_q;
  assign Busy      = state_q != EXEC;
  // Target selection; a set bit0 here means a misaligned branch/jump
  always_comb begin
    next_pc_d = CtrlPCMode == PCINC  ? LinkAddr :
                CtrlPCMode == PCBRCH ? (Flag ? tgt_imm : LinkAddr) :
                CtrlPCMode == PCJREG ? (AluRd & ~32'd1) : tgt_imm;
  end
  // FETCH/EXEC sequencing; Redirect overrides everything, the trap flag is a one-cycle pulse
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= FETCH;
      pc_q        <= ResetVector;
      fetch_req_q <= 1'b0;
      trap_q      <= 1'b0;
      trap_val_q  <= '0;
      instret_q   <= '0;
    end else begin
      trap_q <= 1'b0;
      if (Redirect) begin
        pc_q        <= RedirectAddr & ~32'd1;
        state_q     <= FETCH;
        fetch_req_q <= 1'b1;
      end else if (state_q == FETCH) begin
        state_q     <= FetchAck ? EXEC : FETCH;
        fetch_req_q <= !FetchAck;
      end else if (Step) begin
        state_q     <= FETCH;
        fetch_req_q <= 1'b1;
        if (next_pc_d[0]) begin
          pc_q       <= TrapVector;
          trap_val_q <= next_pc_d;
          trap_q     <= 1'b1;
        end else begin
          pc_q      <= next_pc_d;
          instret_q <= instret_q + 32'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized checks against a transaction-level PC model
module tb_pc_sequencer;
  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [1:0]  CtrlPCMode = 2'b00;
  logic        InstrCompressed = 1'b0;
  logic [31:0] Imm = '0, AluRd = '0, RedirectAddr = '0;
  logic        Flag = 1'b0, Step = 1'b0, Redirect = 1'b0, FetchAck = 1'b0;
  logic        FetchReq, MisalignTrap, Busy;
  logic [31:0] FetchAddr, PC, LinkAddr, TrapValue, InstRet;

  pc_sequencer dut (
    .Clk(Clk), .Reset(Reset), .CtrlPCMode(CtrlPCMode), .InstrCompressed(InstrCompressed),
    .Imm(Imm), .AluRd(AluRd), .Flag(Flag), .Step(Step), .Redirect(Redirect),
    .RedirectAddr(RedirectAddr), .FetchReq(FetchReq), .FetchAddr(FetchAddr),
    .FetchAck(FetchAck), .PC(PC), .LinkAddr(LinkAddr), .MisalignTrap(MisalignTrap),
    .TrapValue(TrapValue), .InstRet(InstRet), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0, n_pass = 0;
  // reference state: executing flag rather than an encoded FSM
  bit          m_exec, m_req, m_trap;
  logic [31:0] m_pc, m_tval, m_iret;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_exec = 0; m_req = 0; m_trap = 0; m_pc = 32'h0; m_tval = 0; m_iret = 0;
  endtask

  // one clock of architectural behaviour computed from the input values at the edge
  task automatic model_step();
    longint unsigned tgt;
    longint unsigned len = InstrCompressed ? 2 : 4;
    longint unsigned sx = {{32{Imm[31]}}, Imm};
    m_trap = 0;
    if (Redirect) begin
      m_pc = {RedirectAddr[31:1], 1'b0}; m_exec = 0; m_req = 1;
    end else if (!m_exec) begin
      m_exec = FetchAck; m_req = !FetchAck;
    end else if (Step) begin
      case (CtrlPCMode)
        2'd0: tgt = m_pc + len;
        2'd1: tgt = Flag ? m_pc + sx : m_pc + len;
        2'd2: tgt = {33'd0, AluRd[31:1]} * 2;
        default: tgt = m_pc + sx;
      endcase
      tgt = tgt % 64'h1_0000_0000;
      m_exec = 0; m_req = 1;
      if (tgt % 2 == 1) begin
        m_tval = tgt[31:0]; m_pc = 32'h10; m_trap = 1;
      end else begin
        m_pc = tgt[31:0]; m_iret = m_iret + 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"}, PC, m_pc);
    check({tag, ".faddr"}, FetchAddr, m_pc);
    check({tag, ".freq"}, {31'd0, FetchReq}, {31'd0, m_req});
    check({tag, ".busy"}, {31'd0, Busy}, {31'd0, !m_exec});
    check({tag, ".trap"}, {31'd0, MisalignTrap}, {31'd0, m_trap});
    check({tag, ".tval"}, TrapValue, m_tval);
    check({tag, ".iret"}, InstRet, m_iret);
    check({tag, ".link"}, LinkAddr, m_pc + (InstrCompressed ? 32'd2 : 32'd4));
  endtask

  task automatic cycle(input string tag);
    @(posedge Clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic set_pc(input logic [31:0] a);
    Redirect = 1; RedirectAddr = a; cycle("redir");
    Redirect = 0; FetchAck = 1; cycle("ack");
    FetchAck = 0;
  endtask

  task automatic step(input logic [1:0] m, input logic ic, input logic [31:0] im,
                      input logic [31:0] rd, input logic f);
    CtrlPCMode = m; InstrCompressed = ic; Imm = im; AluRd = rd; Flag = f; Step = 1;
    cycle("step");
    Step = 0;
  endtask

  initial begin
    logic [31:0] ir;
    model_reset();
    repeat (2) @(posedge Clk);
    #1 check_all("reset");
    #2 Reset = 0;
    cycle("rel");
    check("rel_freq", {31'd0, FetchReq}, 32'd1);
    check("rel_faddr", FetchAddr, 32'h0);
    FetchAck = 1; cycle("ack0"); FetchAck = 0;
    check("ack_busy", {31'd0, Busy}, 32'd0);
    step(2'b00, 0, 0, 0, 0);
    check("inc_pc", PC, 32'h4);
    check("inc_iret", InstRet, 32'd1);
    set_pc(32'h100); step(2'b01, 0, 32'hFFFF_FFF8, 0, 1);
    check("brch_taken", PC, 32'hF8);
    set_pc(32'h100); InstrCompressed = 1; #1;
    check("link_c", LinkAddr, 32'h102);
    step(2'b01, 1, 32'hFFFF_FFF8, 0, 0);
    check("brch_nt", PC, 32'h102);
    FetchAck = 1; cycle("ack"); FetchAck = 0;
    step(2'b10, 0, 0, 32'h2001, 0);
    check("jreg", PC, 32'h2000);
    check("jreg_trap", {31'd0, MisalignTrap}, 32'd0);
    set_pc(32'h40); ir = InstRet;
    step(2'b11, 0, 32'h7, 0, 0);
    check("jimm_pc", PC, 32'h10);
    check("jimm_tval", TrapValue, 32'h47);
    check("jimm_trap", {31'd0, MisalignTrap}, 32'd1);
    check("jimm_iret", InstRet, ir);
    cycle("trap_end");
    check("trap_pulse", {31'd0, MisalignTrap}, 32'd0);
    set_pc(32'hFFFF_FFFE);
    @(negedge Clk);
    force dut.instret_q = 32'hFFFF_FFFF;
    #1 release dut.instret_q;
    m_iret = 32'hFFFF_FFFF;
    step(2'b00, 1, 0, 0, 0);
    check("pc_wrap", PC, 32'h0);
    check("iret_wrap", InstRet, 32'h0);
    Redirect = 1; RedirectAddr = 32'h801; FetchAck = 1; cycle("redir_ack");
    Redirect = 0; FetchAck = 0;
    check("ra_pc", PC, 32'h800);
    check("ra_busy", {31'd0, Busy}, 32'd1);
    FetchAck = 1; cycle("ack"); FetchAck = 0;
    ir = InstRet;
    Redirect = 1; RedirectAddr = 32'h801; Step = 1; CtrlPCMode = 2'b00; cycle("redir_step");
    Redirect = 0; Step = 0;
    check("rs_pc", PC, 32'h800);
    check("rs_iret", InstRet, ir);
    set_pc(32'h300);
    #2 Reset = 1;
    #1 model_reset();
    check("ar_pc", PC, 32'h0);
    check("ar_trap", {31'd0, MisalignTrap}, 32'd0);
    check("ar_freq", {31'd0, FetchReq}, 32'd0);
    check("ar_iret", InstRet, 32'd0);
    @(posedge Clk);
    #2 Reset = 0;
    cycle("rel2");
    for (int i = 0; i < 400; i++) begin
      Redirect = ($urandom_range(0, 15) == 0);
      RedirectAddr = $urandom;
      FetchAck = $urandom_range(0, 1);
      Step = $urandom_range(0, 1);
      CtrlPCMode = 2'($urandom_range(0, 3));
      InstrCompressed = $urandom_range(0, 1);
      Imm = ($urandom_range(0, 3) == 0) ? $urandom : 32'($signed($urandom_range(0, 512)) - 256);
      AluRd = $urandom;
      Flag = $urandom_range(0, 1);
      cycle("rnd");
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter stage directly downstream of the integer unit in the multi-cycle RV32EC core.
- Owns the architectural PC and consumes the integer unit's Flag (branch condition) and Rd (JALR target), plus the decoder's PC-write mode and immediate.
- Drives the fetch request handshake, produces the link address, detects misaligned targets and counts retired instructions.

Parameters:
- ResetVector, 32'h0000_0000: PC loaded on reset.
- TrapVector, 32'h0000_0010: PC loaded on a misaligned-target trap.

Ports:
- Clk  in  1  core clock.
- Reset  in  1  asynchronous, active-high reset.
- CtrlPCMode  in  2  PC write mode: 00 PCINC, 01 PCBRCH, 10 PCJREG, 11 PCJIMM.
- InstrCompressed  in  1  current instruction is 16-bit.
- Imm  in  32  sign-extended branch/jump offset.
- AluRd  in  32  integer unit result (JALR target).
- Flag  in  1  integer unit condition flag (branch taken).
- Step  in  1  retire strobe from the sequencer; sampled only in EXEC.
- Redirect  in  1  external redirect (interrupt/exception entry).
- RedirectAddr  in  32  target for Redirect.
- FetchReq  out  1  fetch request.
- FetchAddr  out  32  fetch address (equals PC).
- FetchAck  in  1  fetch accepted/complete.
- PC  out  32  current architectural PC.
- LinkAddr  out  32  PC + instruction length, for JAL/JALR rd.
- MisalignTrap  out  1  one-cycle pulse on misaligned target.
- TrapValue  out  32  offending target, held until the next trap.
- InstRet  out  32  retired-instruction count.
- Busy  out  1  high whenever state is not EXEC.

Behaviour:
- Reset (async): PC=ResetVector, state=FETCH, MisalignTrap=0, TrapValue=0, InstRet=0.
  - FetchReq is registered and reads 0 while Reset is asserted; it reads 1 in the first cycle after Reset deasserts.
- FetchAddr = PC at all times. Busy = (state != EXEC).
- States:
  - FETCH: FetchReq=1. FetchAck → EXEC next cycle. Step is ignored.
  - EXEC: FetchReq=0. Step → compute NextPC, register PC, go to FETCH. No Step → hold.
- Len = InstrCompressed ? 2 : 4. LinkAddr = PC + Len (combinational; meaningful in EXEC).
- NextPC by mode:
  - PCINC: PC+Len.
  - PCBRCH: Flag ? PC+Imm : PC+Len.
  - PCJREG: AluRd with bit0 cleared.
  - PCJIMM: PC+Imm.
- All adds are modulo 2^32; wrap from 32'hFFFF_FFFE+2 gives 0, with no flag.
- Misaligned: NextPC[0]=1; only reachable via PCBRCH-taken or PCJIMM with odd Imm.
  - PC=TrapVector, TrapValue=NextPC, MisalignTrap=1 for exactly that cycle, InstRet not incremented, go to FETCH.
- Non-trapping Step: InstRet += 1, wraps at 2^32.
- Redirect has highest priority in any state:
  - PC=RedirectAddr with bit0 cleared; go to FETCH.
  - Simultaneous FetchAck and Step are ignored; InstRet is unchanged.
  - A fetch in flight is abandoned; the fetch unit must treat the next FetchReq cycle as a new request.
- FetchAck in EXEC is ignored.
- Reset mid-fetch or mid-EXEC: immediate return to reset values; no partial PC update.

Decomposition:
- Shared package pc_pkg:
  - PC mode constants PCINC/PCBRCH/PCJREG/PCJIMM (2-bit).
  - State enum {FETCH, EXEC}.
  - Instruction-length constants.
- No sub-module; the next-PC adder and mux stay inline.

Test Plan:
- Reset release → FetchReq=1, FetchAddr=0x0. FetchAck → Busy=0. Step with PCINC and InstrCompressed=0 → PC=0x4, InstRet=1.
- PC=0x100, PCBRCH, Imm=-8, Flag=1 → PC=0xF8. Repeat with Flag=0, InstrCompressed=1 → PC=0x102. LinkAddr before Step = 0x102.
- PCJREG with AluRd=0x2001 → PC=0x2000, no trap. PCJIMM with PC=0x40, Imm=0x7 → PC=0x10, TrapValue=0x47, MisalignTrap pulse of 1 cycle, InstRet unchanged.
- PC=0xFFFF_FFFE, PCINC, InstrCompressed=1 → PC=0x0. InstRet preloaded to 0xFFFF_FFFF by 2^32-1 steps, or forced in the bench, wraps to 0.
- Redirect with RedirectAddr=0x801 in the same cycle as FetchAck → next state FETCH, PC=0x800. Redirect coincident with Step → PC=0x800, InstRet unchanged.
- Reset asserted mid-EXEC with PC=0x300 → PC=0x0 and MisalignTrap=0 immediately (asynchronous, before the next clock edge).
